// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared constants, access decode type and address-width helper for dpram
package dpram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_RAM_DEPTH  = 16;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_WRITE = 2'd1,
        ACC_READ  = 2'd2
    } access_e;

    // Same result as $clog2 for any positive depth.
    function automatic int addr_width(input int depth);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dpram_mem_array.sv
// rtl/dpram_mem_array.sv - word storage with synchronous write and asynchronous clear
module dpram_mem_array
    import dpram_pkg::*;
#(
    parameter int WORD_W = DEFAULT_DATA_WIDTH,
    parameter int DEPTH  = DEFAULT_RAM_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         we,
    input  logic [addr_width(DEPTH)-1:0] addr,
    input  logic [WORD_W-1:0]            wdata,
    output logic [WORD_W-1:0]            rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[addr] = wdata;
        end
    end

    // Reset wipes every word so no partial write survives an aborted access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dpram.sv
// rtl/dpram.sv - single-port-address RAM with registered read; optional parity via DPRAM_PARITY_EN
module dpram
    import dpram_pkg::*;
#(
    parameter int Data_Width = DEFAULT_DATA_WIDTH,
    parameter int RAM_Depth  = DEFAULT_RAM_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cs,
    input  logic                             oe,
    input  logic                             wr_en,
    input  logic [addr_width(RAM_Depth)-1:0] addr,
    input  logic [Data_Width-1:0]            data_in,
    output logic [Data_Width-1:0]            data_out
`ifdef DPRAM_PARITY_EN
    ,
    output logic                             parity_err
`endif
);

`ifdef DPRAM_PARITY_EN
    localparam int WORD_W = Data_Width + 1;
`else
    localparam int WORD_W = Data_Width;
`endif

    access_e               acc;
    logic [WORD_W-1:0]     wr_word;
    logic [WORD_W-1:0]     rd_word;
    logic [Data_Width-1:0] data_out_q;
    logic [Data_Width-1:0] data_out_d;

    // Write wins over read when both are requested.
    always_comb begin
        acc = ACC_IDLE;
        if (cs) begin
            if (wr_en) begin
                acc = ACC_WRITE;
            end else if (oe) begin
                acc = ACC_READ;
            end
        end
    end

`ifdef DPRAM_PARITY_EN
    assign wr_word = {^data_in, data_in};
`else
    assign wr_word = data_in;
`endif

    dpram_mem_array #(
        .WORD_W (WORD_W),
        .DEPTH  (RAM_Depth)
    ) u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (acc == ACC_WRITE),
        .addr  (addr),
        .wdata (wr_word),
        .rdata (rd_word)
    );

    always_comb begin
        data_out_d = data_out_q;
        if (acc == ACC_READ) begin
            data_out_d = rd_word[Data_Width-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

`ifdef DPRAM_PARITY_EN
    logic stored_par;
    logic parity_err_q;
    logic parity_err_d;

    assign stored_par = rd_word[Data_Width];

    always_comb begin
        parity_err_d = parity_err_q;
        if (acc == ACC_READ) begin
            parity_err_d = stored_par ^ (^rd_word[Data_Width-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_dpram.sv
// tb/tb_dpram.sv - randomized self-checking bench for dpram against an array reference model
module tb_dpram;

    logic       clk;
    logic       rst_n;
    logic       cs;
    logic       oe;
    logic       wr_en;
    logic [3:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
`ifdef DPRAM_PARITY_EN
    logic       parity_err;
`endif

    int n_cmp;
    int n_err;

    logic [7:0] ref_mem [16];
    logic [7:0] ref_out;

    dpram #(
        .Data_Width (8),
        .RAM_Depth  (16)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .oe       (oe),
        .wr_en    (wr_en),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
`ifdef DPRAM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        ref_out = 8'h00;
    endtask

    // Called at a falling edge: drive, apply the rules at the rising edge, check at the next falling edge.
    task automatic step(input logic c, input logic o, input logic w,
                        input logic [3:0] a, input logic [7:0] d, input string tag);
        cs = c; oe = o; wr_en = w; addr = a; data_in = d;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (c && w) begin
            ref_mem[a] = d;
        end else if (c && o) begin
            ref_out = ref_mem[a];
        end
        @(negedge clk);
        check(tag, {24'h0, data_out}, {24'h0, ref_out});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        model_reset();
        cs = 1'b0; oe = 1'b0; wr_en = 1'b0; addr = '0; data_in = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 check("reset_data_out", {24'h0, data_out}, 32'h0);

        // Writes attempted while reset is held must be ignored.
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 4'(i), 8'($urandom), "reset_hold");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'(i), 8'h00, "post_reset_read");
        end

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 1'b1, 4'(i), 8'(i) ^ 8'hA5, "fill_write");
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'(i), 8'($urandom), "fill_read");
            check("fill_value", {24'h0, data_out}, {24'h0, 8'(i) ^ 8'hA5});
        end

`ifdef DPRAM_PARITY_EN
        begin
            logic bad_par;
            bad_par = ~(^ref_mem[7]);
            force u_dut.stored_par = bad_par;
            step(1'b1, 1'b1, 1'b0, 4'd7, 8'h00, "par_read_bad");
            check("parity_err_set", {31'h0, parity_err}, 32'h1);
            release u_dut.stored_par;
            step(1'b1, 1'b1, 1'b0, 4'd6, 8'h00, "par_read_clean");
            check("parity_err_clear", {31'h0, parity_err}, 32'h0);
        end
`endif

        step(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, "pre_gate_read");
        step(1'b0, 1'b0, 1'b1, 4'd3, 8'hFF, "cs_low_write");
        step(1'b0, 1'b1, 1'b0, 4'd9, 8'h00, "cs_low_read");
        step(1'b0, 1'b1, 1'b1, 4'd3, 8'hFF, "cs_low_both");
        step(1'b1, 1'b1, 1'b0, 4'd3, 8'h00, "cs_gate_readback");
        check("cs_gate_value", {24'h0, data_out}, 32'hA6);

        step(1'b1, 1'b1, 1'b1, 4'd5, 8'h3C, "oe_we_write");
        check("oe_we_hold", {24'h0, data_out}, 32'hA6);
        step(1'b1, 1'b1, 1'b0, 4'd5, 8'h00, "oe_we_readback");
        check("oe_we_value", {24'h0, data_out}, 32'h3C);

        step(1'b1, 1'b0, 1'b1, 4'd15, 8'h81, "b2b_write");
        step(1'b1, 1'b1, 1'b0, 4'd15, 8'h00, "b2b_read");
        check("b2b_value", {24'h0, data_out}, 32'h81);

        // Reset lands in the middle of a read cycle and must clear data_out at once.
        cs = 1'b1; oe = 1'b1; wr_en = 1'b0; addr = 4'd2;
        #2 rst_n = 1'b0;
        #1 check("mid_read_reset", {24'h0, data_out}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("reset_held_out", {24'h0, data_out}, 32'h0);
        rst_n = 1'b1;
        step(1'b1, 1'b1, 1'b0, 4'd15, 8'h00, "cleared_15");
        step(1'b1, 1'b1, 1'b0, 4'd2, 8'h00, "cleared_2");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                 4'($urandom), 8'($urandom), "random");
        end

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 1'b0, 4'(i), 8'h00, "final_sweep");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dpram.md
DPRAM -- requirements
Module: dpram

Interface
REQ-001 Parameter Data_Width, default 8: word width in bits, minimum 1.
REQ-002 Parameter RAM_Depth, default 16: number of words, a power of two, minimum 2.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port cs, input, 1 bit: chip select; no access when low.
REQ-006 Port oe, input, 1 bit: output enable, a read request.
REQ-007 Port wr_en, input, 1 bit: write enable.
REQ-008 Port addr, input, $clog2(RAM_Depth) bits: word address shared by read and write.
REQ-009 Port data_in, input, Data_Width bits: write data.
REQ-010 Port data_out, output, Data_Width bits: registered read data.

Function
REQ-011 Write: at a rising clk edge with cs=1, wr_en=1, the block SHALL store data_in into mem[addr].
REQ-012 Read: at a rising clk edge with cs=1, oe=1, wr_en=0, the block SHALL load mem[addr] into data_out, visible one cycle after the request edge.
REQ-013 When cs=1, wr_en=1 and oe=1 in the same cycle, the write SHALL complete and data_out SHALL hold its previous value.
REQ-014 When cs=0, the block SHALL neither write memory nor update data_out, regardless of oe, wr_en or addr.
REQ-015 When cs=1 and oe=0 and wr_en=0, data_out SHALL hold its previous value.
REQ-016 A read of an address written in the immediately preceding cycle SHALL return the newly written data.
REQ-017 Every addr value is a legal address; there is no wrap-around or out-of-range case, because RAM_Depth is a power of two.
REQ-018 A location never written since power-up SHALL read as 0.

Reset
REQ-019 rst_n=0 SHALL immediately force data_out to 0, independent of clk.
REQ-020 rst_n=0 SHALL asynchronously clear all RAM_Depth memory words to 0.
REQ-021 While rst_n=0, writes and reads SHALL be ignored.
REQ-022 The first access SHALL take effect on the first rising edge at which rst_n=1.
REQ-023 Reset asserted mid-operation SHALL abort the access in progress; no partial write is retained.

Configuration
REQ-024 Macro DPRAM_PARITY_EN:
- When defined, each word SHALL store one extra even-parity bit, computed from data_in on write.
- When defined, the block SHALL add the port parity_err (output, 1 bit, registered, reset 0), set in the same cycle as data_out on a read whose stored parity mismatches, cleared on the next clean read.
- When undefined, there SHALL be no parity storage and no parity_err port.

Structure
REQ-025 Package dpram_pkg SHALL hold the default width/depth constants and an address-width function equivalent to $clog2.
REQ-026 The storage array with its write and clear logic SHALL be the sub-module dpram_mem_array. The top level SHALL hold the access decode, the data_out register and the parity logic.

Verification
REQ-027 Reset: hold rst_n=0 with cs=1, wr_en=1 for 3 cycles, release, then read addr 0..15 -> every read returns 0x00; data_out=0x00 during reset.
REQ-028 Fill and readback: write data_in=addr^8'hA5 to addr 0..15, then read addr 0..15 -> data_out=addr^8'hA5, one cycle after each request edge.
REQ-029 Chip select gating: with cs=0, wr_en=1, write 0xFF to addr 3, then read addr 3 with cs=1 -> previous contents, not 0xFF; data_out never changes while cs=0.
REQ-030 Simultaneous oe and wr_en: write 0x3C to addr 5 with oe=1, then read addr 5 -> data_out unchanged during the write cycle, then 0x3C.
REQ-031 Back-to-back: write 0x81 to addr 15 at edge N, read addr 15 at edge N+1 -> data_out=0x81 after edge N+1; assert rst_n=0 mid-read -> data_out=0x00 immediately.
REQ-032 DPRAM_PARITY_EN build: force a stored parity bit to flip on addr 7, then read addr 7 -> parity_err=1 with data_out; read a clean address next -> parity_err=0.
